// File: rtl/param_counter_pkg.sv
// param_counter_pkg
//   Shared definitions for the parameterised up/down counter:
//   - mode_e        : behaviour at the count limits (wrap or saturate)
//   - DEFAULT_WIDTH : default counter width in bits
//   - DEFAULT_DIV   : default prescale ratio (enabled cycles per count step)
package param_counter_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIV   = 1;

endpackage : param_counter_pkg

// File: rtl/strobe_divider.sv
// strobe_divider
//   Prescaler that counts 0..DIV-1 on enabled cycles and raises a
//   combinational strobe on the enabled cycle where the count is DIV-1.
//   The count returns to 0 on that same edge.
//
// Ports
//   clock   : sole clock, all state on posedge
//   reset_  : asynchronous active-low reset, discards any partial count
//   enable  : advances the count when high, holds it when low
//   clear   : synchronous clear; wins over enable and suppresses strobe
//   strobe  : high during the cycle whose posedge completes a prescale period
module strobe_divider #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset_,
  input  logic enable,
  input  logic clear,
  output logic strobe
);

  // At DIV=1 a 0-bit count is impossible, so keep one bit. LAST is then 0,
  // the register never leaves 0, and strobe collapses to enable & ~clear.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign strobe    = enable & ~clear & w_at_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule : strobe_divider

// File: rtl/param_counter.sv
// param_counter
//   Prescaled up/down counter with wrap or saturate behaviour at the limits.
//   One count step happens per DIV enabled cycles; load overrides everything.
//
// Parameters
//   WIDTH : counter width in bits (2..32)
//   DIV   : prescale ratio, enabled cycles per step (1..256)
//   MODE  : MODE_WRAP or MODE_SATURATE
//
// Ports
//   clock      : sole clock, all state on posedge
//   reset_     : asynchronous active-low reset
//   enable     : advances the prescaler when high, pauses it when low
//   up         : 1 increment, 0 decrement; sampled at the step edge
//   load       : synchronous load, highest priority
//   load_value : value written on load
//   counter    : registered count
//   tick       : one-cycle pulse after every edge that attempted a step
//   overflow   : one-cycle pulse after every step that wrapped or was blocked
//   at_max     : counter == all-ones (combinational)
//   at_min     : counter == 0 (combinational)
module param_counter
  import param_counter_pkg::*;
#(
  parameter int    WIDTH = DEFAULT_WIDTH,
  parameter int    DIV   = DEFAULT_DIV,
  parameter mode_e MODE  = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             overflow,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_overflow;

  logic             w_step;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_next;

  // Load doubles as the prescaler clear, so a load edge is never a step edge
  // and the next step comes a full DIV enabled edges later.
  strobe_divider #(
    .DIV (DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset_ (reset_),
    .enable (enable),
    .clear  (load),
    .strobe (w_step)
  );

  assign at_max = (r_count == '1);
  assign at_min = (r_count == '0);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next     = up ? r_count + 1'b1 : r_count - 1'b1;
    w_at_limit = up ? at_max : at_min;
    // Modulo arithmetic already wraps; saturation just refuses the move.
    if (w_at_limit && (MODE == MODE_SATURATE)) begin
      w_next = r_count;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (load) begin
      r_count    <= load_value;
      r_tick     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // A blocked saturating step still counts as an attempted step.
      r_tick     <= w_step;
      r_overflow <= w_step & w_at_limit;
      if (w_step) begin
        r_count <= w_next;
      end
    end
  end

  assign counter  = r_count;
  assign tick     = r_tick;
  assign overflow = r_overflow;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// tb_param_counter
//   Four counters with different WIDTH/DIV/MODE share one set of inputs:
//     dut0: WIDTH=4,  DIV=1, WRAP
//     dut1: WIDTH=4,  DIV=3, WRAP
//     dut2: WIDTH=8,  DIV=1, SATURATE
//     dut3: WIDTH=16, DIV=4, WRAP
//   A behavioural model tracks each counter as plain integers; directed
//   scenarios add fixed expected values on top of the model.
module tb_param_counter;
  import param_counter_pkg::*;

  logic        clock = 1'b0;
  logic        reset_;
  logic        enable;
  logic        up;
  logic        load;
  logic [15:0] load_value;

  logic [3:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;
  logic [15:0] cnt_d;
  logic [3:0]  tick_v;
  logic [3:0]  ov_v;
  logic [3:0]  amax_v;
  logic [3:0]  amin_v;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int   m_cnt  [4];
  int   m_pre  [4];
  logic m_tick [4];
  logic m_ov   [4];

  always #5 clock = ~clock;

  param_counter #(.WIDTH(4), .DIV(1), .MODE(MODE_WRAP)) u_dut0 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value[3:0]), .counter(cnt_a), .tick(tick_v[0]),
    .overflow(ov_v[0]), .at_max(amax_v[0]), .at_min(amin_v[0])
  );

  param_counter #(.WIDTH(4), .DIV(3), .MODE(MODE_WRAP)) u_dut1 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value[3:0]), .counter(cnt_b), .tick(tick_v[1]),
    .overflow(ov_v[1]), .at_max(amax_v[1]), .at_min(amin_v[1])
  );

  param_counter #(.WIDTH(8), .DIV(1), .MODE(MODE_SATURATE)) u_dut2 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value[7:0]), .counter(cnt_c), .tick(tick_v[2]),
    .overflow(ov_v[2]), .at_max(amax_v[2]), .at_min(amin_v[2])
  );

  param_counter #(.WIDTH(16), .DIV(4), .MODE(MODE_WRAP)) u_dut3 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .counter(cnt_d), .tick(tick_v[3]),
    .overflow(ov_v[3]), .at_max(amax_v[3]), .at_min(amin_v[3])
  );

  function automatic int width_of(input int d);
    case (d)
      0, 1:    return 4;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int div_of(input int d);
    case (d)
      1:       return 3;
      3:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] dut_count(input int d);
    case (d)
      0:       return {28'd0, cnt_a};
      1:       return {28'd0, cnt_b};
      2:       return {24'd0, cnt_c};
      default: return {16'd0, cnt_d};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_cnt[d]  = 0;
      m_pre[d]  = 0;
      m_tick[d] = 1'b0;
      m_ov[d]   = 1'b0;
    end
  endtask

  // One clock edge of every counter, from the behavioural rules.
  task automatic model_edge(input logic en, input logic u, input logic ld,
                            input logic [15:0] lv);
    for (int d = 0; d < 4; d++) begin
      int mx;
      mx = (1 << width_of(d)) - 1;
      m_tick[d] = 1'b0;
      m_ov[d]   = 1'b0;
      if (ld) begin
        m_cnt[d] = int'(lv) & mx;
        m_pre[d] = 0;
      end else if (en) begin
        if (m_pre[d] < div_of(d) - 1) begin
          m_pre[d] = m_pre[d] + 1;
        end else begin
          m_pre[d]  = 0;
          m_tick[d] = 1'b1;
          if (u) begin
            if (m_cnt[d] == mx) begin
              m_ov[d] = 1'b1;
              if (d != 2) m_cnt[d] = 0;
            end else begin
              m_cnt[d] = m_cnt[d] + 1;
            end
          end else begin
            if (m_cnt[d] == 0) begin
              m_ov[d] = 1'b1;
              if (d != 2) m_cnt[d] = mx;
            end else begin
              m_cnt[d] = m_cnt[d] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    for (int d = 0; d < 4; d++) begin
      int   mx;
      logic exp_max;
      logic exp_min;
      mx      = (1 << width_of(d)) - 1;
      exp_max = (m_cnt[d] == mx);
      exp_min = (m_cnt[d] == 0);
      n_checks++;
      if (dut_count(d) !== 32'(m_cnt[d])) begin
        n_errors++;
        $display("FAIL %s dut%0d counter: got %0h expected %0h", tag, d, dut_count(d), m_cnt[d]);
      end
      n_checks++;
      if (tick_v[d] !== m_tick[d]) begin
        n_errors++;
        $display("FAIL %s dut%0d tick: got %b expected %b", tag, d, tick_v[d], m_tick[d]);
      end
      n_checks++;
      if (ov_v[d] !== m_ov[d]) begin
        n_errors++;
        $display("FAIL %s dut%0d overflow: got %b expected %b", tag, d, ov_v[d], m_ov[d]);
      end
      n_checks++;
      if (amax_v[d] !== exp_max) begin
        n_errors++;
        $display("FAIL %s dut%0d at_max: got %b expected %b", tag, d, amax_v[d], exp_max);
      end
      n_checks++;
      if (amin_v[d] !== exp_min) begin
        n_errors++;
        $display("FAIL %s dut%0d at_min: got %b expected %b", tag, d, amin_v[d], exp_min);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic en, input logic u, input logic ld,
                      input logic [15:0] lv, input string tag);
    enable     = en;
    up         = u;
    load       = ld;
    load_value = lv;
    model_edge(en, u, ld, lv);
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  task automatic apply_reset();
    reset_     = 1'b0;
    enable     = 1'b0;
    up         = 1'b0;
    load       = 1'b0;
    load_value = '0;
    model_reset();
    #2;
    compare_model("reset");
    @(posedge clock);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (cnt_d !== 16'h0000 || tick_v !== 4'b0000 || ov_v !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_values: got cnt_d=%h tick=%b ov=%b expected 0000/0000/0000", cnt_d, tick_v, ov_v);
    end
  endtask

  task automatic test_wrap_up();
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] exp_c;
      exp_c = (i <= 15) ? 4'(i) : 4'(i - 16);
      step(1'b1, 1'b1, 1'b0, '0, "wrap_up");
      n_checks++;
      if (cnt_a !== exp_c || ov_v[0] !== (i == 16)) begin
        n_errors++;
        $display("FAIL wrap_up edge %0d: got cnt=%0d ov=%b expected cnt=%0d ov=%b", i, cnt_a, ov_v[0], exp_c, (i == 16));
      end
    end
  endtask

  task automatic test_div3_down();
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] exp_c;
      exp_c = (i < 3) ? 4'd0 : (i < 6) ? 4'd15 : 4'd14;
      step(1'b1, 1'b0, 1'b0, '0, "div3_down");
      n_checks++;
      if (cnt_b !== exp_c || tick_v[1] !== (i % 3 == 0) || ov_v[1] !== (i == 3)) begin
        n_errors++;
        $display("FAIL div3_down edge %0d: got cnt=%0d tick=%b ov=%b expected cnt=%0d tick=%b ov=%b",
                 i, cnt_b, tick_v[1], ov_v[1], exp_c, (i % 3 == 0), (i == 3));
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 16'd254, "sat_load");
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, "saturate");
      n_checks++;
      if (cnt_c !== 8'd255 || ov_v[2] !== (i >= 2) || amax_v[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL saturate step %0d: got cnt=%0d ov=%b at_max=%b expected cnt=255 ov=%b at_max=1",
                 i, cnt_c, ov_v[2], amax_v[2], (i >= 2));
      end
    end
    // Saturate at zero going down.
    step(1'b0, 1'b0, 1'b1, 16'd0, "sat_load0");
    step(1'b1, 1'b0, 1'b0, '0, "saturate_min");
    step(1'b1, 1'b0, 1'b0, '0, "saturate_min");
  endtask

  task automatic test_pause();
    apply_reset();
    step(1'b1, 1'b1, 1'b0, '0, "pause_run");
    step(1'b1, 1'b1, 1'b0, '0, "pause_run");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, "pause_idle");
      n_checks++;
      if (tick_v !== 4'b0000 || ov_v !== 4'b0000) begin
        n_errors++;
        $display("FAIL pause_idle: got tick=%b ov=%b expected 0000/0000", tick_v, ov_v);
      end
    end
    step(1'b1, 1'b1, 1'b0, '0, "pause_run");
    n_checks++;
    if (tick_v[3] !== 1'b0 || cnt_d !== 16'd0) begin
      n_errors++;
      $display("FAIL pause_3rd: got tick=%b cnt=%h expected 0/0000", tick_v[3], cnt_d);
    end
    step(1'b1, 1'b1, 1'b0, '0, "pause_run");
    n_checks++;
    if (tick_v[3] !== 1'b1 || cnt_d !== 16'd1) begin
      n_errors++;
      $display("FAIL pause_4th: got tick=%b cnt=%h expected 1/0001", tick_v[3], cnt_d);
    end
  endtask

  task automatic test_load_priority();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, "ldp_pre");
    step(1'b1, 1'b1, 1'b1, 16'h1234, "ldp_load");
    n_checks++;
    if (cnt_d !== 16'h1234 || tick_v !== 4'b0000) begin
      n_errors++;
      $display("FAIL ldp_load: got cnt=%h tick=%b expected 1234/0000", cnt_d, tick_v);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, "ldp_after");
      n_checks++;
      if (tick_v[3] !== (i == 4) || cnt_d !== ((i == 4) ? 16'h1235 : 16'h1234)) begin
        n_errors++;
        $display("FAIL ldp_after edge %0d: got tick=%b cnt=%h expected tick=%b", i, tick_v[3], cnt_d, (i == 4));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 16'h00AB, "ar_load");
    step(1'b1, 1'b1, 1'b0, '0, "ar_pre");
    step(1'b1, 1'b1, 1'b0, '0, "ar_pre");
    // Mid-cycle, well before the next posedge.
    #2;
    reset_ = 1'b0;
    model_reset();
    #1;
    compare_model("async_reset");
    n_checks++;
    if (cnt_d !== 16'h0000 || tick_v !== 4'b0000 || ov_v !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_reset: got cnt=%h tick=%b ov=%b expected 0000/0000/0000", cnt_d, tick_v, ov_v);
    end
    #2;
    reset_ = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, "ar_after");
      n_checks++;
      if (tick_v[3] !== (i == 4)) begin
        n_errors++;
        $display("FAIL ar_after edge %0d: got tick=%b expected %b", i, tick_v[3], (i == 4));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        en;
      logic        u;
      logic        ld;
      logic [15:0] lv;
      en = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 5) != 0) ^ (i >= 750);
      ld = ($urandom_range(0, 40) == 0);
      lv = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(en, u, ld, lv, "random");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap_up();
    test_div3_down();
    test_saturate();
    test_pause();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_param_counter
